// File: rtl/text_render.sv
// ---------------------------------------------------------------------------
// text_render
//
// Character-mode scan-out engine. Follows the VGA controller's pixel
// coordinates and tracks the current 9x16 character cell without a divider.
// It reads the cell's character code from video memory and looks up the glyph
// row in a registered font ROM. It emits one 24-bit pixel per clock with a
// blinking underline cursor on glyph rows 14 and 15. The text area is
// 70x30 cells (630x480 pixels). Every output is exactly 4 clocks behind its
// coordinate inputs.
//
// Ports
//   clk, reset             pixel clock, synchronous active-high reset
//   h_addr, v_addr, valid  pixel coordinates and visible-region flag
//   hsync_in, vsync_in     raw syncs, delayed to hsync_out/vsync_out
//   cur_x, cur_y           cursor cell position
//   x, y                   cell address to video memory (registered, S1)
//   ascii_in               combinational video memory read data for {x,y}
//   font_addr              {ascii, glyph_row} to font ROM (from S2)
//   font_data              font ROM row, one cycle after font_addr
//   vga_data               pixel colour
//   hsync_out, vsync_out   delayed syncs
//   valid_out              delayed valid
// ---------------------------------------------------------------------------
module text_render #(
  parameter int unsigned BLINK_CYCLES = 32'd12500000,
  parameter logic [23:0] FG_COLOR     = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR     = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  input  logic        valid,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [6:0]  cur_x,
  input  logic [4:0]  cur_y,
  output logic [6:0]  x,
  output logic [4:0]  y,
  input  logic [7:0]  ascii_in,
  output logic [11:0] font_addr,
  input  logic [11:0] font_data,
  output logic [23:0] vga_data,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        valid_out
);

  localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYCLES - 32'd1);
  localparam logic [6:0]  TEXT_COLS  = 7'd70;
  localparam logic [3:0]  CELL_LAST  = 4'd8;

  // Cell tracker (doubles as the S1 column/cell registers)
  logic [6:0]  tx_r;
  logic [3:0]  tcol_r;
  logic        locked_r;

  // S1 sideband
  logic [4:0]  y_r;
  logic [3:0]  s1_row_r;
  logic        s1_valid_r;
  logic        s1_hs_r;
  logic        s1_vs_r;
  logic [6:0]  s1_cur_x_r;
  logic [4:0]  s1_cur_y_r;

  // S2
  logic [7:0]  s2_ascii_r;
  logic [3:0]  s2_row_r;
  logic [3:0]  s2_col_r;
  logic        s2_act_r;
  logic        s2_hit_r;
  logic        s2_valid_r;
  logic        s2_hs_r;
  logic        s2_vs_r;

  // S3 (aligned with font_data)
  logic [3:0]  s3_col_r;
  logic        s3_act_r;
  logic        s3_hit_r;
  logic        s3_valid_r;
  logic        s3_hs_r;
  logic        s3_vs_r;

  // Output registers
  logic [23:0] vga_data_r;
  logic        hsync_out_r;
  logic        vsync_out_r;
  logic        valid_out_r;

  // Blink timer
  logic [31:0] blink_cnt_r;
  logic        blink_on_r;

  // Combinational S1 decode and pixel select
  logic        blank_s;
  logic        hit_pre_s;
  logic [23:0] pix_s;

  // v_addr[9] is never needed (rows stop at 479); font bits 11..9 are unused.
  logic        unused_s;
  assign unused_s = &{1'b0, v_addr[9], font_data[11:9]};

  // Cell tracker: lock on column 0, then count 9 pixels per cell; holds when
  // valid is low so blanking gaps inside a line do not disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_r     <= 7'd0;
      tcol_r   <= 4'd0;
      locked_r <= 1'b0;
    end else if (valid) begin
      if (h_addr == 10'd0) begin
        tx_r     <= 7'd0;
        tcol_r   <= 4'd0;
        locked_r <= 1'b1;
      end else if (tcol_r == CELL_LAST) begin
        tcol_r <= 4'd0;
        // Saturate at 70 so the right margin stays blank instead of wrapping.
        if (tx_r != TEXT_COLS) begin
          tx_r <= tx_r + 7'd1;
        end
      end else begin
        tcol_r <= tcol_r + 4'd1;
      end
    end
  end

  // S1 sideband capture: row, glyph row, syncs, valid and cursor position
  always_ff @(posedge clk) begin
    if (reset) begin
      y_r        <= 5'd0;
      s1_row_r   <= 4'd0;
      s1_valid_r <= 1'b0;
      s1_hs_r    <= 1'b1;
      s1_vs_r    <= 1'b1;
      s1_cur_x_r <= 7'd0;
      s1_cur_y_r <= 5'd0;
    end else begin
      y_r        <= v_addr[8:4];
      s1_row_r   <= v_addr[3:0];
      s1_valid_r <= valid;
      s1_hs_r    <= hsync_in;
      s1_vs_r    <= vsync_in;
      s1_cur_x_r <= cur_x;
      s1_cur_y_r <= cur_y;
    end
  end

  // S1 decode: blanking and cursor hit for the pixel currently in S1
  always_comb begin
    blank_s   = 1'b1;
    hit_pre_s = 1'b0;
    if (s1_valid_r && locked_r && (tx_r < TEXT_COLS)) begin
      blank_s = 1'b0;
    end else begin
      blank_s = 1'b1;
    end
    if ((tx_r == s1_cur_x_r) && (y_r == s1_cur_y_r) &&
        (s1_row_r[3:1] == 3'b111) && blink_on_r) begin
      hit_pre_s = 1'b1;
    end else begin
      hit_pre_s = 1'b0;
    end
  end

  // S2: capture the character code that video memory returns for {x,y}.
  // The active flag is stored (rather than blank) so reset means "blank".
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_ascii_r <= 8'd0;
      s2_row_r   <= 4'd0;
      s2_col_r   <= 4'd0;
      s2_act_r   <= 1'b0;
      s2_hit_r   <= 1'b0;
      s2_valid_r <= 1'b0;
      s2_hs_r    <= 1'b1;
      s2_vs_r    <= 1'b1;
    end else begin
      s2_ascii_r <= ascii_in;
      s2_row_r   <= s1_row_r;
      s2_col_r   <= tcol_r;
      s2_act_r   <= ~blank_s;
      s2_hit_r   <= hit_pre_s;
      s2_valid_r <= s1_valid_r;
      s2_hs_r    <= s1_hs_r;
      s2_vs_r    <= s1_vs_r;
    end
  end

  assign font_addr = {s2_ascii_r, s2_row_r};

  // S3: sideband delayed one more cycle to line up with the ROM read data
  always_ff @(posedge clk) begin
    if (reset) begin
      s3_col_r   <= 4'd0;
      s3_act_r   <= 1'b0;
      s3_hit_r   <= 1'b0;
      s3_valid_r <= 1'b0;
      s3_hs_r    <= 1'b1;
      s3_vs_r    <= 1'b1;
    end else begin
      s3_col_r   <= s2_col_r;
      s3_act_r   <= s2_act_r;
      s3_hit_r   <= s2_hit_r;
      s3_valid_r <= s2_valid_r;
      s3_hs_r    <= s2_hs_r;
      s3_vs_r    <= s2_vs_r;
    end
  end

  // Pixel select: blank pixels are black, not the background colour
  always_comb begin
    pix_s = 24'h000000;
    if (s3_act_r) begin
      if (font_data[s3_col_r] | s3_hit_r) begin
        pix_s = FG_COLOR;
      end else begin
        pix_s = BG_COLOR;
      end
    end else begin
      pix_s = 24'h000000;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_data_r  <= 24'h000000;
      hsync_out_r <= 1'b1;
      vsync_out_r <= 1'b1;
      valid_out_r <= 1'b0;
    end else begin
      vga_data_r  <= pix_s;
      hsync_out_r <= s3_hs_r;
      vsync_out_r <= s3_vs_r;
      valid_out_r <= s3_valid_r;
    end
  end

  // Blink timer: free-running, toggles the cursor phase at terminal count
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_r <= 32'd0;
      blink_on_r  <= 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= 32'd0;
      blink_on_r  <= ~blink_on_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + 32'd1;
    end
  end

  assign x         = tx_r;
  assign y         = y_r;
  assign vga_data  = vga_data_r;
  assign hsync_out = hsync_out_r;
  assign vsync_out = vsync_out_r;
  assign valid_out = valid_out_r;

endmodule

// File: tb/tb_text_render.sv
// ---------------------------------------------------------------------------
// tb_text_render
//
// Directed bench for text_render. Each driven pixel pushes its expected
// colour/syncs/valid into a scoreboard queue, tagged with the cycle in which
// the output must appear. A negedge monitor pops and compares. The video
// memory returns ascii = x. The font ROM is a registered model with a
// selectable content mode.
// ---------------------------------------------------------------------------
module tb_text_render;

  localparam int          BLINK = 16;
  localparam logic [23:0] FG    = 24'hF0E0D0;
  localparam logic [23:0] BG    = 24'h102030;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic        valid;
  logic        hsync_in;
  logic        vsync_in;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic [6:0]  x;
  logic [4:0]  y;
  logic [7:0]  ascii_in;
  logic [11:0] font_addr;
  logic [11:0] font_data;
  logic [23:0] vga_data;
  logic        hsync_out;
  logic        vsync_out;
  logic        valid_out;

  text_render #(
    .BLINK_CYCLES (BLINK),
    .FG_COLOR     (FG),
    .BG_COLOR     (BG)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .h_addr    (h_addr),
    .v_addr    (v_addr),
    .valid     (valid),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .x         (x),
    .y         (y),
    .ascii_in  (ascii_in),
    .font_addr (font_addr),
    .font_data (font_data),
    .vga_data  (vga_data),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  // Video memory model: each cell holds its own column number.
  assign ascii_in = {1'b0, x};

  int font_mode = 0;

  function automatic logic [11:0] font_fn(input int mode, input logic [11:0] a);
    logic [11:0] r;
    case (mode)
      0:       r = a * 12'd37 + 12'd5;
      1:       r = 12'h001;
      default: r = 12'h000;
    endcase
    return r;
  endfunction

  // Registered font ROM model
  always @(posedge clk) font_data <= font_fn(font_mode, font_addr);

  typedef struct {
    int          due;
    int          tag;
    logic [23:0] vga;
    logic        hs;
    logic        vs;
    logic        vld;
  } exp_t;

  typedef struct {
    int         due;
    int         tag;
    logic [6:0] xv;
  } xexp_t;

  exp_t  q[$];
  xexp_t xq[$];

  int cyc     = 0;
  int tests   = 0;
  int fails   = 0;
  bit m_locked = 1'b0;
  int reset_k  = 0;
  bit chk_x    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: compare every scoreboard entry that falls due this cycle
  always @(negedge clk) begin : mon
    exp_t  e;
    xexp_t xe;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      tests++;
      assert (vga_data === e.vga) else begin
        fails++;
        $error("FAIL vga_data h=%0d cyc=%0d got %h exp %h", e.tag, cyc, vga_data, e.vga);
      end
      tests++;
      assert ({valid_out, hsync_out, vsync_out} === {e.vld, e.hs, e.vs}) else begin
        fails++;
        $error("FAIL valid/hs/vs h=%0d cyc=%0d got %b%b%b exp %b%b%b", e.tag, cyc,
               valid_out, hsync_out, vsync_out, e.vld, e.hs, e.vs);
      end
    end
    while (xq.size() > 0 && xq[0].due <= cyc) begin
      xe = xq.pop_front();
      tests++;
      assert (x === xe.xv) else begin
        fails++;
        $error("FAIL x h=%0d got %0d exp %0d", xe.tag, x, xe.xv);
      end
    end
  end

  // Drive one pixel (or a reset cycle), record its expectations, advance one clock
  task automatic step(input int h, input int v, input bit vld, input bit hs,
                      input bit vs, input bit rst);
    exp_t        e;
    xexp_t       xe;
    int          xc;
    int          col;
    logic [9:0]  vv;
    logic [11:0] f;
    bit          bitv;
    bit          hit;
    reset    = rst;
    h_addr   = 10'(h);
    v_addr   = 10'(v);
    valid    = vld;
    hsync_in = hs;
    vsync_in = vs;
    if (rst) begin
      m_locked = 1'b0;
      reset_k  = cyc;
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      while (xq.size() > 0 && xq[$].due > cyc) void'(xq.pop_back());
      for (int i = 1; i <= 4; i++) begin
        e.due = cyc + i; e.tag = -1; e.vga = 24'h000000;
        e.hs = 1'b1; e.vs = 1'b1; e.vld = 1'b0;
        q.push_back(e);
      end
    end else begin
      if (vld && h == 0) m_locked = 1'b1;
      xc  = h / 9;
      col = h % 9;
      vv  = 10'(v);
      e.due = cyc + 4; e.tag = h; e.hs = hs; e.vs = vs; e.vld = vld;
      if (!vld || !m_locked || h >= 630) begin
        e.vga = 24'h000000;
      end else begin
        f    = font_fn(font_mode, {8'(xc), vv[3:0]});
        bitv = f[col];
        hit  = (xc == int'(cur_x)) && (int'(vv[8:4]) == int'(cur_y)) &&
               (vv[3:0] >= 4'd14) && ((((cyc - reset_k) / BLINK) % 2) == 1);
        e.vga = (bitv || hit) ? FG : BG;
      end
      q.push_back(e);
      if (chk_x && vld) begin
        xe.due = cyc + 1;
        xe.tag = h;
        xe.xv  = (xc >= 70) ? 7'd70 : 7'(xc);
        xq.push_back(xe);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b0, (i % 3) != 1, 1'b1, 1'b0);
  endtask

  initial begin
    int vlist [6];
    vlist = '{46, 47, 45, 46, 47, 46};
    cur_x = 7'd3;
    cur_y = 5'd2;

    // Reset, then idle with syncs high
    repeat (3) step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (10) step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Line scan on row 0 with cell address checking
    font_mode = 0;
    chk_x = 1'b1;
    for (int h = 0; h < 640; h++) step(h, 0, 1'b1, (h % 7) != 3, 1'b1, 1'b0);
    chk_x = 1'b0;
    idle(6);

    // Glyph check: only the leftmost pixel of each cell lit
    font_mode = 1;
    for (int h = 0; h < 640; h++) step(h, 5, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(6);

    // Cursor blink on cell (3,2); gaps shift the blink phase line to line
    font_mode = 2;
    for (int li = 0; li < 6; li++) begin
      for (int h = 0; h <= 40; h++) step(h, vlist[li], 1'b1, 1'b1, 1'b1, 1'b0);
      for (int g = 0; g < 7 + 8 * li; g++) step(0, 0, 1'b0, 1'b1, g != 2, 1'b0);
    end
    idle(6);

    // Reset mid-line at h=300 with hsync low around it
    font_mode = 0;
    for (int h = 0; h < 640; h++)
      step(h, 100, 1'b1, !(h >= 296 && h <= 305), 1'b1, h == 300);
    for (int h = 0; h < 640; h++) step(h, 101, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(6);

    // valid gap of 5 cycles between h=100 and h=101
    for (int h = 0; h <= 100; h++) step(h, 200, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (5) step(100, 200, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int h = 101; h < 640; h++) step(h, 200, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(6);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && (q.size() > 0 || xq.size() > 0); i++) @(posedge clk);
    #1;
    tests++;
    assert ((q.size() + xq.size()) == 0) else begin
      fails++;
      $error("FAIL drain pending=%0d exp 0", q.size() + xq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/text_render.md
# text_render

Character-mode scan-out engine on the display side of the text console. It consumes the VGA controller's pixel coordinates and reads the character cell from video memory. It fetches the glyph row from the font ROM and produces one 24-bit pixel per clock, overlaying a blinking underline cursor. The screen is 70×30 cells of 9×16 pixels, and the pipeline is fixed at 4 cycles; sync signals are delayed to match.

## Interface
- BLINK_CYCLES, 12500000, clk cycles per cursor blink phase (0.5 s at 25 MHz)
- FG_COLOR, 24'hFFFFFF, glyph/cursor pixel colour
- BG_COLOR, 24'h000000, background colour inside the 630×480 text area
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- h_addr  in  10  current pixel column from VGA controller, 0..639
- v_addr  in  10  current pixel row, 0..479
- valid  in  1  h_addr/v_addr in visible region
- hsync_in, vsync_in  in  1 each  raw syncs from VGA controller
- cur_x  in  7  cursor cell column, 0..69
- cur_y  in  5  cursor cell row, 0..29
- x  out  7  cell column to video memory (registered, S1)
- y  out  5  cell row to video memory (registered, S1)
- ascii_in  in  8  video memory combinational read data for {x,y}
- font_addr  out  12  {ascii, glyph_row} to font ROM (driven from S2)
- font_data  in  12  font ROM row, registered read (1 cycle); bit 0 = leftmost pixel, bits 8..0 used
- vga_data  out  24  pixel colour
- hsync_out, vsync_out  out  1 each  syncs delayed 4 cycles
- valid_out  out  1  valid delayed 4 cycles

## Operation
- Cell tracker (no divider): registers (tx, tcol, locked).
  - valid & h_addr==0: x=0, col=0, locked=1.
  - valid & h_addr!=0: col==8 → col=0, x=x+1; else col=col+1.
  - valid low: tracker holds.
  - tx saturates at 70; it never wraps.
- y = v_addr[8:4], glyph_row = v_addr[3:0].
- Blank = !valid | !locked | x≥70. Blank pixels output 24'h0 (not BG_COLOR).
- Cursor hit = (x==cur_x) & (y==cur_y) & glyph_row∈{14,15} & blink_on.
  - cur_x/cur_y are sampled in S1.
- Pixel = blank ? 0 : (font_data[col] | cursor_hit) ? FG_COLOR : BG_COLOR.
- Blink: 32-bit counter counts 0..BLINK_CYCLES-1 every clk, independent of valid.
  - At terminal count it returns to 0 and blink_on toggles.
- Reset:
  - Pipeline registers, tracker, counter, blink_on, vga_data, valid_out, x, y all → 0.
  - locked → 0; hsync_out/vsync_out → 1.
- Reset mid-frame: all pixels stay blank until the next valid & h_addr==0 re-locks the tracker.
- ascii 0 is not special; glyph content comes from the ROM.

## Timing
- Stage edges (input presented in cycle N):
  - edge N+1 → S1: x, y, col, glyph_row, blank, cursor_hit_pre, sync, valid. x/y drive video memory.
  - edge N+2 → S2: ascii_in captured, sideband forwarded. font_addr = {S2.ascii, S2.glyph_row}.
  - edge N+3 → ROM presents font_data; S3 sideband aligned with it.
  - edge N+4 → vga_data, hsync_out, vsync_out, valid_out registered.
- Latency exactly 4 cycles for every output, with no stalls. Throughput is 1 pixel/clk.
- The video memory write port may change ascii_in in any cycle. The value captured at N+2 is used, and no hazard protection is provided.
- Blink toggle takes effect for pixels whose S1 capture occurs after the toggle edge.

## Test plan
- Reset then idle (valid=0, syncs=1 for 10 cycles):
  - vga_data=0, valid_out=0 and hsync_out=vsync_out=1 throughout.
  - Counter does not toggle blink before BLINK_CYCLES.
- Line scan, v_addr=0, h_addr 0..639, memory model returns ascii = x:
  - x output sequence 0×9, 1×9, …, 69×9, then 70 for h 630..639.
  - Columns 630..639 give vga_data=0.
- Glyph check, font model returns 12'h001 for all addresses, v_addr=5:
  - Output is FG at h=0,9,18,… and BG elsewhere within 0..629.
  - Each pixel appears exactly 4 cycles after its h_addr.
- Cursor at (3,2), BLINK_CYCLES=16, font all-zero, rows v=46,47, h=27..35:
  - FG during blink_on phases and BG during off phases; toggles every 16 cycles.
  - v=45 never shows the cursor.
- Reset asserted mid-line at h=300 for 1 cycle, scan continues:
  - Output blank until next h_addr==0, then correct cells from x=0.
  - hsync_out=1 for the 4 cycles following reset.
- valid gaps: valid low for 5 cycles between h=100 and h=101 (h_addr held):
  - Tracker holds; pixel 101 still maps to x=11, col=2.
  - valid_out mirrors the input gap delayed by 4.
